// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults and the receiver lock-state encoding, used by
// both the sync capture block and the timing generator.
package vga_timing_pkg;

    localparam int H_TOTAL_DEF  = 800;
    localparam int V_TOTAL_DEF  = 525;
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int HS_START_DEF = 656;
    localparam int VS_START_DEF = 490;
    localparam int HS_WIDTH_DEF = 96;
    localparam int VS_WIDTH_DEF = 2;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lock_state_e;

    // Next counter value with wrap at the last position.
    function automatic logic [9:0] wrap_inc(input logic [9:0] value, input logic [9:0] last);
        if (value == last) begin
            wrap_inc = 10'd0;
        end else begin
            wrap_inc = value + 10'd1;
        end
    endfunction

endpackage

// File: rtl/vga_rx_lock_fsm.sv
// Lock tracker: compares predicted counter positions against the sync edges
// and decides whether the reconstructed timing can be trusted.
module vga_rx_lock_fsm
    import vga_timing_pkg::*;
#(
    parameter logic [9:0] HS_START = 10'd656,
    parameter logic [9:0] VS_START = 10'd490
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       hs_fall,
    input  logic       vs_fall,
    input  logic [9:0] h_pred,
    input  logic [9:0] v_pred,
    output logic       locked,
    output logic       lock_next
);

    lock_state_e state_r;
    lock_state_e state_next_s;
    logic        locked_r;
    logic        bad_edge_s;
    logic        good_vs_s;

    // Next-state decision; a misplaced edge always wins over a good one.
    always_comb begin
        state_next_s = state_r;
        bad_edge_s   = (hs_fall && (h_pred != HS_START)) || (vs_fall && (v_pred != VS_START));
        good_vs_s    = vs_fall && (v_pred == VS_START);
        case (state_r)
            SEARCH: begin
                if (vs_fall) begin
                    state_next_s = VERIFY;
                end else begin
                    state_next_s = SEARCH;
                end
            end
            VERIFY: begin
                if (bad_edge_s) begin
                    state_next_s = SEARCH;
                end else if (good_vs_s) begin
                    state_next_s = LOCKED;
                end else begin
                    state_next_s = VERIFY;
                end
            end
            LOCKED: begin
                if (bad_edge_s) begin
                    state_next_s = SEARCH;
                end else begin
                    state_next_s = LOCKED;
                end
            end
            default: state_next_s = SEARCH;
        endcase
    end

    // State register and registered lock flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= SEARCH;
            locked_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            locked_r <= (state_next_s == LOCKED);
        end
    end

    assign locked    = locked_r;
    assign lock_next = (state_next_s == LOCKED);

endmodule

// File: rtl/vga_sync_capture.sv
// VGA receiver: rebuilds pixel position from hsync/vsync, tracks lock and
// captures the visible pixels. Define CAPTURE_CHECKSUM_EN for a per-frame sum.
module vga_sync_capture
    import vga_timing_pkg::*;
#(
    parameter int H_TOTAL  = H_TOTAL_DEF,
    parameter int V_TOTAL  = V_TOTAL_DEF,
    parameter int HS_START = HS_START_DEF,
    parameter int VS_START = VS_START_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [2:0]  red_in,
    input  logic [2:0]  green_in,
    input  logic [1:0]  blue_in,
    output logic [2:0]  red,
    output logic [2:0]  green,
    output logic [1:0]  blue,
    output logic [9:0]  hcount,
    output logic [9:0]  vcount,
    output logic        pix_valid,
    output logic        locked,
    output logic        frame_start
`ifdef CAPTURE_CHECKSUM_EN
    ,
    output logic [15:0] frame_sum
`endif
);

    localparam logic [9:0] H_LAST_C   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST_C   = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_START_C = 10'(HS_START);
    localparam logic [9:0] VS_START_C = 10'(VS_START);
    localparam logic [9:0] H_ACTIVE_C = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACTIVE_C = 10'(V_ACTIVE);

    logic [1:0] div_r;
    logic       hs_prev_r;
    logic       vs_prev_r;
    logic [9:0] hcount_r;
    logic [9:0] vcount_r;
    logic [2:0] red_r;
    logic [2:0] green_r;
    logic [1:0] blue_r;
    logic       pix_valid_r;
    logic       frame_start_r;

    logic       hs_fall_s;
    logic       vs_fall_s;
    logic       pen_s;
    logic [9:0] h_pred_s;
    logic [9:0] v_pred_s;
    logic [9:0] h_next_s;
    logic [9:0] v_next_s;
    logic       lock_next_s;
    logic       valid_next_s;
    logic       start_next_s;

    // Edge detect, pixel enable and counter prediction. vsync is only
    // compared between pens so a fall is always seen on a pixel boundary.
    always_comb begin
        hs_fall_s = hs_prev_r & ~hsync;
        pen_s     = (div_r == 2'd0) | hs_fall_s;
        vs_fall_s = pen_s & vs_prev_r & ~vsync;
        h_pred_s  = wrap_inc(hcount_r, H_LAST_C);
        if (hcount_r == H_LAST_C) begin
            v_pred_s = wrap_inc(vcount_r, V_LAST_C);
        end else begin
            v_pred_s = vcount_r;
        end
        if (hs_fall_s) begin
            h_next_s = HS_START_C;
        end else begin
            h_next_s = h_pred_s;
        end
        if (vs_fall_s) begin
            v_next_s = VS_START_C;
        end else begin
            v_next_s = v_pred_s;
        end
        valid_next_s = lock_next_s && (h_next_s < H_ACTIVE_C) && (v_next_s < V_ACTIVE_C);
        start_next_s = lock_next_s && (h_next_s == 10'd0) && (v_next_s == 10'd0);
    end

    vga_rx_lock_fsm #(
        .HS_START (HS_START_C),
        .VS_START (VS_START_C)
    ) u_lock (
        .clock     (clock),
        .reset     (reset),
        .hs_fall   (hs_fall_s),
        .vs_fall   (vs_fall_s),
        .h_pred    (h_pred_s),
        .v_pred    (v_pred_s),
        .locked    (locked),
        .lock_next (lock_next_s)
    );

    // Divider, position counters and pixel capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_r         <= 2'd0;
            hs_prev_r     <= 1'b1;
            vs_prev_r     <= 1'b1;
            hcount_r      <= 10'd0;
            vcount_r      <= 10'd0;
            red_r         <= 3'd0;
            green_r       <= 3'd0;
            blue_r        <= 2'd0;
            pix_valid_r   <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            hs_prev_r     <= hsync;
            frame_start_r <= pen_s & start_next_s;
            if (hs_fall_s) begin
                div_r <= 2'd1;
            end else begin
                div_r <= div_r + 2'd1;
            end
            if (pen_s) begin
                vs_prev_r   <= vsync;
                hcount_r    <= h_next_s;
                vcount_r    <= v_next_s;
                pix_valid_r <= valid_next_s;
                if (valid_next_s) begin
                    red_r   <= red_in;
                    green_r <= green_in;
                    blue_r  <= blue_in;
                end else begin
                    red_r   <= 3'd0;
                    green_r <= 3'd0;
                    blue_r  <= 2'd0;
                end
            end
        end
    end

`ifdef CAPTURE_CHECKSUM_EN
    logic [15:0] acc_r;
    logic [15:0] frame_sum_r;
    logic [15:0] pix_word_s;

    assign pix_word_s = {8'd0, red_in, green_in, blue_in};

    // Frame checksum: pixel (0,0) already belongs to the new frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_r       <= 16'd0;
            frame_sum_r <= 16'd0;
        end else if (pen_s && start_next_s) begin
            frame_sum_r <= acc_r;
            if (valid_next_s) begin
                acc_r <= pix_word_s;
            end else begin
                acc_r <= 16'd0;
            end
        end else if (pen_s && valid_next_s) begin
            acc_r <= acc_r + pix_word_s;
        end else begin
            acc_r <= acc_r;
        end
    end

    assign frame_sum = frame_sum_r;
`endif

    assign hcount      = hcount_r;
    assign vcount      = vcount_r;
    assign red         = red_r;
    assign green       = green_r;
    assign blue        = blue_r;
    assign pix_valid   = pix_valid_r;
    assign frame_start = frame_start_r;

endmodule
